// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM encoding, data-memory map constants and defaults.
package mem_arbiter_pkg;
    typedef enum logic {IDLE, ACK} state_t;
    localparam int LOW_WORDS = 8;
    localparam int NUM_WORDS = 10;
    localparam logic [31:0] ADDR_W8 = 32'd96;
    localparam logic [31:0] ADDR_W9 = 32'd100;
    localparam int MAX_WAIT_DEF = 8;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: Wishbone classic bus between an external master and the arbiter slave port.
interface mem_arbiter_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    modport master (output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
                    input  wbs_ack_o, wbs_dat_o);
    modport slave  (input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
                    output wbs_ack_o, wbs_dat_o);
endinterface

// File: rtl/mem_arbiter_addr_decode.sv
// mem_addr_decode: byte address to 10-word array index plus mapped flag.
module mem_addr_decode
    import mem_arbiter_pkg::*;
(
    input  logic [31:0] addr_i,
    output logic [3:0]  idx_o,
    output logic        mapped_o
);
    logic low;
    always_comb begin
        low      = addr_i[31:2] < 30'(LOW_WORDS);
        idx_o    = low ? addr_i[5:2] : addr_i == ADDR_W8 ? 4'd8 : addr_i == ADDR_W9 ? 4'd9 : 4'd0;
        mapped_o = low | (addr_i == ADDR_W8) | (addr_i == ADDR_W9);
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one data-memory array between the core and a Wishbone slave port,
// with the core favoured until a Wishbone request has waited MAX_WAIT cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [31:0]   core_addr,
    input  logic [31:0]   core_wdata,
    output logic [31:0]   core_rdata,
    output logic          core_stall,
    mem_arbiter_if.slave  wbs,
    output logic          mem_we,
    output logic [3:0]    mem_idx,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic [15:0]   stat_conflicts
);
    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [15:0] conf_q, conf_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  core_idx, wb_idx;
    logic        core_map, wb_map, wb_pending, core_gnt, wb_gnt;

    mem_addr_decode u_core_dec (.addr_i(core_addr),     .idx_o(core_idx), .mapped_o(core_map));
    mem_addr_decode u_wb_dec   (.addr_i(wbs.wbs_adr_i), .idx_o(wb_idx),   .mapped_o(wb_map));

    always_comb begin
        wb_pending = wbs.wbs_stb_i & wbs.wbs_cyc_i & (state_q == IDLE);
        core_gnt   = core_req & (!wb_pending | (wait_q < 4'(MAX_WAIT)));
        wb_gnt     = wb_pending & !core_gnt;
        state_d    = wb_gnt ? ACK : IDLE;
        // wait only grows while the core is holding off a live request
        wait_d     = (wb_pending & !wb_gnt) ? ((wait_q == 4'(MAX_WAIT)) ? wait_q : wait_q + 4'd1) : 4'd0;
        conf_d     = (core_req & wb_pending & (conf_q != 16'hFFFF)) ? conf_q + 16'd1 : conf_q;
        dat_d      = (wb_gnt & !wbs.wbs_we_i) ? (wb_map ? mem_rdata : 32'h0) : dat_q;
        mem_idx    = core_gnt ? core_idx : wb_gnt ? wb_idx : 4'd0;
        mem_we     = core_gnt ? (core_we & core_map) : (wb_gnt & wbs.wbs_we_i & wb_map);
        mem_wdata  = core_gnt ? core_wdata : wb_gnt ? wbs.wbs_dat_i : 32'h0;
        core_stall = core_req & !core_gnt;
        core_rdata = (core_gnt & core_map) ? mem_rdata : 32'h0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            wait_q  <= 4'd0;
            conf_q  <= 16'd0;
            dat_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            conf_q  <= conf_d;
            dat_q   <= dat_d;
        end
    end

    assign wbs.wbs_ack_o = (state_q == ACK);
    assign wbs.wbs_dat_o = dat_q;
    assign stat_conflicts = conf_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table, corner-case sequences and random traffic
// checked against a cycle-level arbitration model with its own copy of the array.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;
    localparam int MAXW = 8;

    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;

    logic        core_req = 1'b0, core_we = 1'b0;
    logic [31:0] core_addr = 32'h0, core_wdata = 32'h0;
    logic [31:0] core_rdata, mem_wdata, mem_rdata;
    logic        core_stall, mem_we;
    logic [3:0]  mem_idx;
    logic [15:0] stat_conflicts;

    mem_arbiter_if wb();

    mem_arbiter #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_stall(core_stall),
        .wbs(wb),
        .mem_we(mem_we), .mem_idx(mem_idx), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stat_conflicts(stat_conflicts)
    );

    logic [31:0] arr [NUM_WORDS] = '{default: 32'h0};
    assign mem_rdata = (int'(mem_idx) < NUM_WORDS) ? arr[int'(mem_idx)] : 32'h0;
    always @(posedge clk) if (mem_we && int'(mem_idx) < NUM_WORDS) arr[int'(mem_idx)] <= mem_wdata;

    int          cmp = 0, bad = 0;
    bit          m_busy = 0;
    int          m_blocked = 0, m_conf = 0;
    logic [31:0] m_dat = 32'h0;
    logic [31:0] m_mem [NUM_WORDS] = '{default: 32'h0};
    logic        obs_stall, obs_ack, obs_we;
    logic [3:0]  obs_idx;
    logic [31:0] obs_rd, obs_dat;
    logic [15:0] obs_stat;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wd;
        bit          e_we;
        logic [3:0]  e_idx;
        logic [31:0] e_rd;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", n, act, exp);
        end
    endtask

    function automatic bit amap(input logic [31:0] a, output int idx);
        idx = 0;
        if (a < 32'd32) begin idx = int'(a) / 4; return 1; end
        if (a == 32'd96) begin idx = 8; return 1; end
        if (a == 32'd100) begin idx = 9; return 1; end
        return 0;
    endfunction

    task automatic step(input bit creq, input bit cwe, input logic [31:0] caddr, input logic [31:0] cwd,
                        input bit stb, input bit wwe, input logic [31:0] wadr, input logic [31:0] wdat);
        bit pend, cok, wok, cm, wm, e_we;
        int ci, wi;
        @(negedge clk);
        core_req = creq; core_we = cwe; core_addr = caddr; core_wdata = cwd;
        wb.wbs_stb_i = stb; wb.wbs_cyc_i = stb; wb.wbs_we_i = wwe; wb.wbs_adr_i = wadr; wb.wbs_dat_i = wdat;
        #2;
        cm   = amap(caddr, ci);
        wm   = amap(wadr, wi);
        pend = stb && !m_busy;
        cok  = creq && (!pend || m_blocked < MAXW);
        wok  = pend && !cok;
        e_we = cok ? (cwe && cm) : (wok && wwe && wm);
        chk("core_stall", 32'(core_stall), 32'(creq && !cok));
        chk("core_rdata", core_rdata, (cok && cm) ? m_mem[ci] : 32'h0);
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_idx", 32'(mem_idx), cok ? ci : wok ? wi : 0);
        if (e_we) chk("mem_wdata", mem_wdata, cok ? cwd : wdat);
        chk("wbs_ack_o", 32'(wb.wbs_ack_o), 32'(m_busy));
        chk("wbs_dat_o", wb.wbs_dat_o, m_dat);
        chk("stat_conflicts", 32'(stat_conflicts), m_conf);
        obs_stall = core_stall; obs_ack = wb.wbs_ack_o; obs_we = mem_we; obs_idx = mem_idx;
        obs_rd = core_rdata; obs_dat = wb.wbs_dat_o; obs_stat = stat_conflicts;
        @(posedge clk); #1;
        if (wok && !wwe) m_dat = wm ? m_mem[wi] : 32'h0;
        if (cok && cwe && cm) m_mem[ci] = cwd;
        else if (wok && wwe && wm) m_mem[wi] = wdat;
        if (creq && pend && m_conf < 65535) m_conf++;
        m_blocked = (pend && !wok) ? ((m_blocked + 1 > MAXW) ? MAXW : m_blocked + 1) : 0;
        m_busy = wok;
    endtask

    task automatic idle_inputs();
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        wb.wbs_stb_i = 0; wb.wbs_cyc_i = 0; wb.wbs_we_i = 0; wb.wbs_adr_i = 0; wb.wbs_dat_i = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1;
        @(negedge clk);
        reset = 0;
        m_busy = 0; m_blocked = 0; m_conf = 0; m_dat = 32'h0;
    endtask

    function automatic logic [31:0] raddr();
        case ($urandom_range(0, 5))
            0, 1, 2: return 32'(4 * $urandom_range(0, 7));
            3:       return 32'd96;
            4:       return 32'd100;
            default: return ($urandom_range(0, 1) == 0) ? 32'd200 : 32'($urandom);
        endcase
    endfunction

    initial begin
        int first;
        idle_inputs();
        tbl[0] = '{1, 32'd96,  32'hDEADBEEF, 1, 4'd8, 32'h0};
        tbl[1] = '{0, 32'd96,  32'h0,        0, 4'd8, 32'hDEADBEEF};
        tbl[2] = '{1, 32'd100, 32'h12345678, 1, 4'd9, 32'h0};
        tbl[3] = '{0, 32'd100, 32'h0,        0, 4'd9, 32'h12345678};
        tbl[4] = '{1, 32'd40,  32'h00000BAD, 0, 4'd0, 32'h0};
        tbl[5] = '{0, 32'd40,  32'h0,        0, 4'd0, 32'h0};
        tbl[6] = '{1, 32'd28,  32'hCAFE0007, 1, 4'd7, 32'h0};
        tbl[7] = '{0, 32'd28,  32'h0,        0, 4'd7, 32'hCAFE0007};
        tbl[8] = '{1, 32'd32,  32'h00000055, 0, 4'd0, 32'h0};
        tbl[9] = '{0, 32'd0,   32'h0,        0, 4'd0, 32'h0};
        #12;
        chk("reset_ack", 32'(wb.wbs_ack_o), 32'h0);
        chk("reset_dat", wb.wbs_dat_o, 32'h0);
        chk("reset_stat", 32'(stat_conflicts), 32'h0);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1, tbl[i].we, tbl[i].addr, tbl[i].wd, 0, 0, 0, 0);
            chk($sformatf("tbl%0d_we", i), 32'(obs_we), 32'(tbl[i].e_we));
            chk($sformatf("tbl%0d_idx", i), 32'(obs_idx), 32'(tbl[i].e_idx));
            chk($sformatf("tbl%0d_rd", i), obs_rd, tbl[i].e_rd);
            chk($sformatf("tbl%0d_stall", i), 32'(obs_stall), 32'h0);
        end
        // Wishbone read of word 9 with the core idle
        step(0, 0, 0, 0, 1, 0, 32'd100, 0);
        chk("wb100_ack_early", 32'(obs_ack), 32'h0);
        step(0, 0, 0, 0, 1, 0, 32'd100, 0);
        chk("wb100_ack", 32'(obs_ack), 32'h1);
        chk("wb100_dat", obs_dat, 32'h12345678);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("wb100_ack_single", 32'(obs_ack), 32'h0);
        // unmapped core write alongside unmapped Wishbone read
        step(1, 1, 32'd40, 32'h77777777, 1, 0, 32'd200, 0);
        chk("unmap_we", 32'(obs_we), 32'h0);
        step(0, 0, 0, 0, 1, 0, 32'd200, 0);
        step(0, 0, 0, 0, 1, 0, 32'd200, 0);
        chk("unmap_ack", 32'(obs_ack), 32'h1);
        chk("unmap_dat", obs_dat, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // starvation bound: Wishbone must win on its MAXW+1-th pending cycle
        do_reset();
        first = 0;
        for (int i = 1; i <= 20 && first == 0; i++) begin
            step(1, 0, 32'd0, 0, 1, 0, 32'd100, 0);
            if (obs_stall) first = i;
        end
        chk("wait_grant_cycle", first, MAXW + 1);
        step(1, 0, 32'd0, 0, 1, 0, 32'd100, 0);
        chk("wait_after_stall", 32'(obs_stall), 32'h0);
        chk("wait_ack", 32'(obs_ack), 32'h1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // conflict counter and reset during ACK
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 32'd0, 0, 1, 0, 32'd4, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("conflicts5", 32'(obs_stat), 32'd5);
        step(0, 0, 0, 0, 1, 0, 32'd100, 0);
        #1;
        chk("pre_reset_ack", 32'(wb.wbs_ack_o), 32'h1);
        reset = 1;
        #1;
        chk("rst_ack_drop", 32'(wb.wbs_ack_o), 32'h0);
        chk("rst_stat", 32'(stat_conflicts), 32'h0);
        chk("rst_dat", wb.wbs_dat_o, 32'h0);
        idle_inputs();
        @(negedge clk);
        reset = 0;
        m_busy = 0; m_blocked = 0; m_conf = 0; m_dat = 32'h0;
        // random traffic against the model
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, raddr(), $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, raddr(), $urandom);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 8: cycles a pending Wishbone request may be blocked by the core before it takes priority (range 1..15).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 core_req  input  1  core requests a data-memory access this cycle.
REQ-005 core_we  input  1  core access is a write.
REQ-006 core_addr  input  32  core byte address.
REQ-007 core_wdata  input  32  core write data.
REQ-008 core_rdata  output  32  core read data, combinational.
REQ-009 core_stall  output  1  core access not granted this cycle; core holds request.
REQ-010 wbs_stb_i, wbs_cyc_i, wbs_we_i  input  1 each  Wishbone classic slave controls.
REQ-011 wbs_adr_i  input  32  Wishbone byte address.
REQ-012 wbs_dat_i  input  32  Wishbone write data.
REQ-013 wbs_ack_o  output  1  Wishbone acknowledge, registered.
REQ-014 wbs_dat_o  output  32  Wishbone read data, registered, valid with ack.
REQ-015 mem_we  output  1  write strobe to shared data-memory array.
REQ-016 mem_idx  output  4  word index 0..9 to array.
REQ-017 mem_wdata  output  32  write data to array.
REQ-018 mem_rdata  input  32  combinational array read data at mem_idx.
REQ-019 stat_conflicts  output  16  count of cycles both requesters were pending.

Function
REQ-020 Address map, byte address A: A[31:2]<8 -> idx A[31:2]; A==96 -> idx 8; A==100 -> idx 9; else unmapped.
REQ-021 Unmapped write: mem_we=0, no state change; unmapped read: returned data 32'h0.
REQ-022 wb_pending = wbs_stb_i & wbs_cyc_i & (state==IDLE).
REQ-023 Grant (combinational): core granted if core_req & (!wb_pending | wait_cnt<MAX_WAIT); else Wishbone granted if wb_pending.
REQ-024 core_stall = core_req & !core_granted; 0 when core_req=0.
REQ-025 Granted requester drives mem_idx, mem_wdata, mem_we (we & mapped); no grant -> mem_we=0, mem_idx=0.
REQ-026 core_rdata = mapped ? mem_rdata : 0 when core granted; 0 otherwise.
REQ-027 FSM states IDLE, ACK; IDLE->ACK on Wishbone grant; ACK->IDLE unconditionally next cycle.
REQ-028 On Wishbone grant, wbs_dat_o <= read ? (mapped ? mem_rdata : 0) : unchanged; wbs_ack_o <= 1.
REQ-029 wbs_ack_o high exactly one cycle (state ACK); Wishbone throughput max one access per 2 cycles.
REQ-030 wait_cnt (4 bit): +1 each cycle wb_pending & not granted, saturating at MAX_WAIT; cleared on Wishbone grant or wb_pending=0.
REQ-031 stat_conflicts +1 each cycle core_req & wb_pending; saturates at 16'hFFFF.
REQ-032 Master dropping stb/cyc before grant: request abandoned, wait_cnt cleared, no ack.
REQ-033 Simultaneous core and Wishbone writes to same index: only granted one writes; other writes in its later grant cycle (last grantee wins).

Reset
REQ-034 Async reset: state=IDLE, wait_cnt=0, wbs_ack_o=0, wbs_dat_o=0, stat_conflicts=0.
REQ-035 Reset during ACK drops the ack; Wishbone master must retry.
REQ-036 Combinational outputs follow REQ-024..026 during reset; core_req ignored-free (no gating required).

Structure
REQ-037 Shared package holds FSM state encoding, map constants (96, 100, 8 low words, 10 total), MAX_WAIT default.
REQ-038 One sub-module mem_addr_decode: 32-bit address -> 4-bit idx + mapped flag; instantiated twice.

Verification
REQ-039 Core write 0xDEADBEEF to addr 96, then read -> mem_we=1 idx=8; read returns 0xDEADBEEF, core_stall=0.
REQ-040 Wishbone read addr 100 with core idle -> wbs_ack_o 1 cycle after stb, wbs_dat_o=array[9], single-cycle ack.
REQ-041 core_req held high continuously, Wishbone read pending (MAX_WAIT=8) -> Wishbone granted on 9th pending cycle, core_stall=1 that cycle only.
REQ-042 Core write to addr 40 (unmapped) and Wishbone read addr 200 -> mem_we=0, read data 0.
REQ-043 Both pending 5 cycles -> stat_conflicts=5; reset asserted during ACK -> ack 0 immediately, all counters 0.
